fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the RV64 core. It owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake, keeping one request outstanding at a time. Returned words go into a 2-entry {pc, instr} buffer that feeds the cpu's decode stage through a valid/ready handshake. The execute stage can redirect fetch for branches; a redirect flushes the buffer and any in-flight response.

Parameters:
RESET_PC, 64'h0, fetch address used after reset
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; held until imem_gnt
imem_addr  out  64  fetch byte address, bits[1:0] always 0
imem_gnt  in  1  memory accepts request this cycle (sampled only while imem_req=1)
imem_rvalid  in  1  read data valid, at least 1 cycle after gnt
imem_rdata  in  32  instruction word
instr_valid  out  1  buffer head valid
instr  out  32  buffer head instruction
instr_pc  out  64  buffer head PC
instr_ready  in  1  consumer takes head when instr_valid=1
redirect  in  1  branch taken; flush and refetch
redirect_pc  in  64  redirect target; bits[1:0] ignored

Behaviour:
- Reset (rst_n=0 at posedge): state=REQ, fetch_pc=RESET_PC, buffer emptied. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- imem_req is asserted in the first cycle after reset is released.
- States:
  - REQ: imem_req=1 iff count<DEPTH. imem_addr=fetch_pc. When imem_req and imem_gnt are both 1, go to WAIT, latch req_pc=fetch_pc, and set fetch_pc+=4 (mod 2^64; wraps to 0).
  - WAIT: imem_req=0. On imem_rvalid, enqueue {req_pc, imem_rdata} and go to REQ. Space is guaranteed because a request is only issued when count<DEPTH.
  - DRAIN: imem_req=0. On imem_rvalid, discard the data and go to REQ.
- imem_rvalid in REQ is ignored. This covers stray responses after a reset mid-transaction.
- Throughput: with gnt in the same cycle and rvalid the next cycle, one instruction every 2 cycles. The first instruction reaches instr_valid in the cycle after rvalid (buffer output is registered).
- Buffer: FIFO order. A dequeue happens when instr_valid && instr_ready. Enqueue and dequeue in the same cycle leave count unchanged. When the buffer is empty, instr_valid=0 and instr/instr_pc hold their last values.
- Redirect (highest priority, acts at posedge):
  - Flush the buffer (instr_valid=0 next cycle). A simultaneous instr_ready is moot.
  - fetch_pc = {redirect_pc[63:2], 2'b00}.
  - From WAIT, go to DRAIN. If imem_rvalid arrives in the same cycle as redirect, that data is discarded and the state goes to REQ.
  - From REQ with the request pending and not granted: imem_addr switches to the new target next cycle and imem_req stays asserted. Memory samples the address only at gnt.
  - From REQ with gnt in the same cycle: the granted request goes to DRAIN and its response is discarded.
  - From DRAIN: stay in DRAIN and update fetch_pc.
- Back-to-back redirects: the last one wins. At most one response is ever dropped per outstanding request.
- Address wrap: fetch_pc 64'hFFFF_FFFF_FFFF_FFFC increments to 64'h0 without error.

Decomposition:
- Package types (alongside control_t):
  - fetch_state_t enum {FETCH_REQ, FETCH_WAIT, FETCH_DRAIN}
  - fetch_entry_t struct {logic [63:0] pc; logic [31:0] instr;}
- Sub-module fetch_fifo (DEPTH entries of fetch_entry_t): synchronous flush, push/pop, count, registered head.
- The FSM and PC logic stay in fetch_ctrl.

Test Plan:
- Reset: RESET_PC=64'h1000, rst_n=0 for 2 cycles -> imem_req=0, instr_valid=0, imem_addr=64'h1000. After release, imem_req=1 with addr 64'h1000 the next cycle.
- Steady fetch: gnt immediate, rvalid+1 with rdata 32'h00500093, instr_ready=1 -> instr_valid=1, instr=32'h00500093, instr_pc=64'h1000. Next req addr=64'h1004.
- Backpressure: instr_ready=0 -> after 2 words buffered, imem_req stays 0. Raise instr_ready -> heads delivered in order 64'h1000, 64'h1004, 64'h1008 with no loss or duplication.
- Redirect in WAIT: request at 64'h1008 granted, redirect with redirect_pc=64'h2000 before rvalid -> rvalid data dropped, instr_valid=0, next req addr=64'h2000, first delivered instr_pc=64'h2000.
- Redirect with gnt stalled: req pending at 64'h1004 with gnt=0, redirect_pc=64'h3002 -> imem_addr=64'h3000 next cycle, held until gnt.
- Wrap and stray response: redirect to 64'hFFFF_FFFF_FFFF_FFFC -> following fetch addr 64'h0. Also, imem_rvalid pulsed in REQ with nothing outstanding -> buffer unchanged.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types for the instruction-fetch sequencer.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered {pc, instr} record
//   control_t     : per-cycle buffer controls produced by the FSM
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic flush;
        logic push;
        logic pop;
    } control_t;

    localparam logic [63:0] PC_STEP = 64'd4;

    // Force word alignment of a fetch address.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with registered head.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : empty the buffer (head value held)
//   push, din    : enqueue an entry (caller guarantees space unless popping)
//   pop          : dequeue the head (ignored when empty)
//   head         : registered head entry; holds last value when empty
//   head_valid   : buffer non-empty
//   full         : buffer holds DEPTH entries
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    fetch_entry_t head_q;
    fetch_entry_t head_nxt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_n;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_n;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_FULL) || do_pop);
        rd_n    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_n   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_n = cnt_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_n = cnt_q - (AW + 1)'(1);
        end
        // The incoming word becomes head when it lands in the slot the head
        // pointer will point at (buffer empty, or single entry being popped).
        head_nxt = (do_push && (wr_ptr == rd_n)) ? din : mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_n;
            cnt_q  <= cnt_n;
            if (cnt_n != '0) begin
                head_q <= head_nxt;
            end
        end
    end

    assign head       = head_q;
    assign head_valid = (cnt_q != '0);
    assign full       = (cnt_q == CNT_FULL);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with one outstanding imem request.
//   clk, rst_n                       : clock, synchronous active-low reset
//   imem_req/imem_addr/imem_gnt      : request handshake (addr word aligned)
//   imem_rvalid/imem_rdata           : read response
//   instr_valid/instr/instr_pc       : buffered instruction to decode
//   instr_ready                      : decode takes the head
//   redirect/redirect_pc             : branch redirect, flushes buffer
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [63:0]  fetch_pc_q, fetch_pc_d;
    logic [63:0]  req_pc_q, req_pc_d;
    control_t     ctrl;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         fifo_full;
    logic         granted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        ctrl       = '0;
        // rst_n gating keeps the request low while reset is held.
        imem_req   = rst_n && (state_q == FETCH_REQ) && !fifo_full;
        granted    = imem_req && imem_gnt;
        push_entry = '{pc: req_pc_q, instr: imem_rdata};

        ctrl.pop = instr_valid && instr_ready;

        unique case (state_q)
            FETCH_REQ: begin
                if (granted) begin
                    state_d    = FETCH_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    ctrl.push = 1'b1;
                    state_d   = FETCH_REQ;
                end
            end
            FETCH_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        // Redirect overrides everything above. Any request still outstanding
        // after this edge has its response drained; a response arriving this
        // very cycle closes the transaction, so fetch resumes immediately.
        if (redirect) begin
            ctrl       = '0;
            ctrl.flush = 1'b1;
            fetch_pc_d = align_pc(redirect_pc);
            unique case (state_q)
                FETCH_REQ:   state_d = granted ? FETCH_DRAIN : FETCH_REQ;
                FETCH_WAIT:  state_d = imem_rvalid ? FETCH_REQ : FETCH_DRAIN;
                FETCH_DRAIN: state_d = imem_rvalid ? FETCH_REQ : FETCH_DRAIN;
                default:     state_d = FETCH_REQ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ctrl.flush),
        .push      (ctrl.push),
        .din       (push_entry),
        .pop       (ctrl.pop),
        .head      (head),
        .head_valid(instr_valid),
        .full      (fifo_full)
    );

    assign imem_addr = fetch_pc_q;
    assign instr     = head.instr;
    assign instr_pc  = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed bench for fetch_ctrl.
module tb_fetch_ctrl;

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [63:0] rpc;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
    } vec_t;

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC(64'h1000),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    function automatic vec_t mk(input logic r, input logic g, input logic v,
                                input logic [31:0] d, input logic rd,
                                input logic rx, input logic [63:0] rp,
                                input logic er, input logic [63:0] ea,
                                input logic ev, input logic [31:0] ei,
                                input logic [63:0] ep);
        vec_t t;
        t.rst_n = r;  t.gnt = g;  t.rv = v;  t.rdata = d;  t.rdy = rd;
        t.redir = rx; t.rpc = rp;
        t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at negedge, clock, then check the post-edge outputs.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n       = v.rst_n;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        instr_ready = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        chk({tag, " imem_req"},    64'(imem_req),    64'(v.e_req));
        chk({tag, " imem_addr"},   imem_addr,        v.e_addr);
        chk({tag, " instr_valid"}, 64'(instr_valid), 64'(v.e_valid));
        chk({tag, " instr"},       64'(instr),       64'(v.e_instr));
        chk({tag, " instr_pc"},    instr_pc,         v.e_pc);
    endtask

    vec_t tbl [27];

    initial begin
        //             rst gnt rv rdata         rdy rx rpc      req addr      vld instr         pc
        tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1000, 0, 32'h0,        64'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1000, 0, 32'h0,        64'h0);
        tbl[2]  = mk(1, 0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h1000, 0, 32'h0,        64'h0);
        tbl[3]  = mk(1, 1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1004, 0, 32'h0,        64'h0);
        tbl[4]  = mk(1, 0, 1, 32'h00500093, 1, 0, 64'h0,    1, 64'h1004, 1, 32'h00500093, 64'h1000);
        tbl[5]  = mk(1, 1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1008, 0, 32'h00500093, 64'h1000);
        tbl[6]  = mk(1, 0, 1, 32'h00100113, 0, 0, 64'h0,    1, 64'h1008, 1, 32'h00100113, 64'h1004);
        tbl[7]  = mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h100c, 1, 32'h00100113, 64'h1004);
        tbl[8]  = mk(1, 0, 1, 32'h00200193, 0, 0, 64'h0,    0, 64'h100c, 1, 32'h00100113, 64'h1004);
        tbl[9]  = mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h100c, 1, 32'h00100113, 64'h1004);
        tbl[10] = mk(1, 0, 0, 32'h0,        1, 0, 64'h0,    1, 64'h100c, 1, 32'h00200193, 64'h1008);
        tbl[11] = mk(1, 0, 0, 32'h0,        1, 0, 64'h0,    1, 64'h100c, 0, 32'h00200193, 64'h1008);
        tbl[12] = mk(1, 1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1010, 0, 32'h00200193, 64'h1008);
        tbl[13] = mk(1, 0, 0, 32'h0,        1, 1, 64'h2000, 0, 64'h2000, 0, 32'h00200193, 64'h1008);
        tbl[14] = mk(1, 0, 1, 32'hdeadbeef, 1, 0, 64'h0,    1, 64'h2000, 0, 32'h00200193, 64'h1008);
        tbl[15] = mk(1, 1, 0, 32'h0,        1, 0, 64'h0,    0, 64'h2004, 0, 32'h00200193, 64'h1008);
        tbl[16] = mk(1, 0, 1, 32'h00300213, 0, 0, 64'h0,    1, 64'h2004, 1, 32'h00300213, 64'h2000);
        tbl[17] = mk(1, 0, 0, 32'h0,        1, 1, 64'h3002, 1, 64'h3000, 0, 32'h00300213, 64'h2000);
        tbl[18] = mk(1, 0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h3000, 0, 32'h00300213, 64'h2000);
        tbl[19] = mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h3004, 0, 32'h00300213, 64'h2000);
        tbl[20] = mk(1, 0, 1, 32'h00400293, 1, 0, 64'h0,    1, 64'h3004, 1, 32'h00400293, 64'h3000);
        tbl[21] = mk(1, 1, 0, 32'h0,        0, 1, TOP,      0, TOP,      0, 32'h00400293, 64'h3000);
        tbl[22] = mk(1, 0, 1, 32'h11111111, 0, 0, 64'h0,    1, TOP,      0, 32'h00400293, 64'h3000);
        tbl[23] = mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h0,    0, 32'h00400293, 64'h3000);
        tbl[24] = mk(1, 0, 1, 32'h00600313, 0, 0, 64'h0,    1, 64'h0,    1, 32'h00600313, TOP);
        tbl[25] = mk(1, 0, 1, 32'h22222222, 0, 0, 64'h0,    1, 64'h0,    1, 32'h00600313, TOP);
        tbl[26] = mk(1, 0, 0, 32'h0,        1, 0, 64'h0,    1, 64'h0,    0, 32'h00600313, TOP);

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Redirect in WAIT with rvalid in the same cycle: data dropped, no drain.
        apply(mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h4,    0, 32'h00600313, TOP), "s_wait");
        apply(mk(1, 0, 1, 32'h33333333, 0, 1, 64'h5000, 1, 64'h5000, 0, 32'h00600313, TOP), "s_redir_rv");
        // Back-to-back redirects, the second while being granted: last wins.
        apply(mk(1, 0, 0, 32'h0,        0, 1, 64'h6000, 1, 64'h6000, 0, 32'h00600313, TOP), "s_bb1");
        apply(mk(1, 1, 0, 32'h0,        0, 1, 64'h7004, 0, 64'h7004, 0, 32'h00600313, TOP), "s_bb2");
        apply(mk(1, 0, 1, 32'h44444444, 0, 0, 64'h0,    1, 64'h7004, 0, 32'h00600313, TOP), "s_drain");
        apply(mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h7008, 0, 32'h00600313, TOP), "s_req7004");
        apply(mk(1, 0, 1, 32'h00700393, 0, 0, 64'h0,    1, 64'h7008, 1, 32'h00700393, 64'h7004), "s_deliver");
        // Reset mid-transaction, then a stray response in REQ is ignored.
        apply(mk(1, 1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h700c, 1, 32'h00700393, 64'h7004), "s_grant");
        apply(mk(0, 0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1000, 0, 32'h0,        64'h0),    "s_rst");
        apply(mk(1, 0, 1, 32'h55555555, 0, 0, 64'h0,    1, 64'h1000, 0, 32'h0,        64'h0),    "s_stray");
        apply(mk(1, 0, 0, 32'h0,        1, 0, 64'h0,    1, 64'h1000, 0, 32'h0,        64'h0),    "s_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
